fir_stim_gen: RTL

//  Producer end of the fir_17 input interface: synthesises signed 8-bit test samples (sine + LFSR noise)
//  and presents them with valid_o, replacing the file-driven noise source feeding fir_17.data_i/valid_i.

---
 rtl/fir_pkg.sv | 49 ++++
 rtl/fir_lfsr16.sv | 34 +++
 rtl/fir_stim_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, sine table, saturation and LFSR helpers
// for the fir_17 stimulus generator.
package fir_pkg;

  localparam int DW = 8;
  localparam logic [15:0] SEED_DEF = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {IDLE, RUN} state_e;

  // round(127*sin(2*pi*k/64))
  localparam logic signed [7:0] SIN_LUT [64] = '{
    8'sd0,    8'sd12,   8'sd25,   8'sd37,
    8'sd49,   8'sd60,   8'sd71,   8'sd81,
    8'sd90,   8'sd98,   8'sd106,  8'sd112,
    8'sd117,  8'sd122,  8'sd125,  8'sd126,
    8'sd127,  8'sd126,  8'sd125,  8'sd122,
    8'sd117,  8'sd112,  8'sd106,  8'sd98,
    8'sd90,   8'sd81,   8'sd71,   8'sd60,
    8'sd49,   8'sd37,   8'sd25,   8'sd12,
    8'sd0,   -8'sd12,  -8'sd25,  -8'sd37,
   -8'sd49,  -8'sd60,  -8'sd71,  -8'sd81,
   -8'sd90,  -8'sd98,  -8'sd106, -8'sd112,
   -8'sd117, -8'sd122, -8'sd125, -8'sd126,
   -8'sd127, -8'sd126, -8'sd125, -8'sd122,
   -8'sd117, -8'sd112, -8'sd106, -8'sd98,
   -8'sd90,  -8'sd81,  -8'sd71,  -8'sd60,
   -8'sd49,  -8'sd37,  -8'sd25,  -8'sd12
  };

  function automatic logic signed [7:0] sat9to8(
    input logic signed [8:0] s
  );
    if (s > 9'sd127)
      return 8'sd127;
    else if (s < -9'sd128)
      return -8'sd128;
    else
      return s[7:0];
  endfunction

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] q
  );
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fir_lfsr16.sv
// fir_lfsr16: 16-bit Fibonacci LFSR noise source, reloadable to SEED.
// Ports: clk, rst (async low), load_i (reseed), adv_i (step), q_o.
module fir_lfsr16
  import fir_pkg::*;
#(
  parameter logic [15:0] SEED = SEED_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        adv_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i)
      q_d = SEED;
    else if (adv_i)
      q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q_q <= SEED;
    else
      q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/fir_stim_gen.sv
// fir_stim_gen: sine + LFSR-noise sample producer for fir_17 self-test.
// Ports: clk, rst (async low), start_i, step_i, noise_en_i, ready_i ->
//   data_o, valid_o, busy_o, done_o (pulse), count_o (accepted samples).
module fir_stim_gen
  import fir_pkg::*;
#(
  parameter int          DW      = fir_pkg::DW,
  parameter int          NVL     = 10000,
  parameter int          DIV     = 4,
  parameter int          PHASE_W = 16,
  parameter logic [15:0] SEED    = SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [PHASE_W-1:0]   step_i,
  input  logic                 noise_en_i,
  input  logic                 ready_i,
  output logic signed [DW-1:0] data_o,
  output logic                 valid_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          count_o
);

  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DIV_LD = DCW'(DIV - 1);
  // The accept cycle itself counts as one divider
  // cycle, so a stream at full rate repeats every DIV.
  localparam logic [DCW-1:0] DIV_RL =
    (DIV > 1) ? DCW'(DIV - 2) : '0;

  state_e                state_q, state_d;
  logic [DCW-1:0]        div_q, div_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [PHASE_W-1:0]    step_q, step_d;
  logic                  noise_q, noise_d;
  logic signed [DW-1:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic [15:0]           count_q, count_d;
  logic                  lfsr_ld, lfsr_adv;
  logic [15:0]           lfsr;

  function automatic logic signed [DW-1:0] mk_sample(
    input logic [PHASE_W-1:0] ph,
    input logic [15:0]        lf,
    input logic               ne
  );
    logic signed [7:0] l;
    logic signed [8:0] s;
    l = SIN_LUT[ph[PHASE_W-1 -: 6]];
    s = {l[7], l};
    if (ne)
      s = s + {{3{lf[5]}}, lf[5:0]};
    return DW'(sat9to8(s));
  endfunction

  fir_lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load_i(lfsr_ld),
    .adv_i (lfsr_adv),
    .q_o   (lfsr)
  );

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    phase_d  = phase_q;
    step_d   = step_q;
    noise_d  = noise_q;
    data_d   = data_q;
    valid_d  = valid_q;
    count_d  = count_q;
    done_d   = 1'b0;
    lfsr_ld  = 1'b0;
    lfsr_adv = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          count_d = '0;
          phase_d = '0;
          lfsr_ld = 1'b1;
          div_d   = DIV_LD;
          step_d  = step_i;
          noise_d = noise_en_i;
        end
      end
      RUN: begin
        if (!valid_q) begin
          if (div_q == '0) begin
            data_d  = mk_sample(phase_q, lfsr, noise_q);
            valid_d = 1'b1;
          end else begin
            div_d = div_q - 1'b1;
          end
        end else if (ready_i) begin
          count_d  = count_q + 16'd1;
          phase_d  = phase_q + step_q;
          lfsr_adv = 1'b1;
          div_d    = DIV_RL;
          valid_d  = 1'b0;
          if (count_q == 16'(NVL - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (DIV == 1) begin
            // back-to-back: build the next sample from
            // the post-accept phase and LFSR state
            data_d  = mk_sample(phase_q + step_q,
                                lfsr_next(lfsr),
                                noise_q);
            valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      phase_q <= '0;
      step_q  <= '0;
      noise_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      noise_q <= noise_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == RUN);
  assign done_o  = done_q;
  assign count_o = count_q;

endmodule
